// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared frame constants, state encoding and frame builder for the SPI host
package spi_pkg;

    localparam int SPI_FRAME_BITS  = 16;
    localparam int SPI_RD_BIT      = 15;
    localparam int SPI_ADDR_W      = 7;
    localparam int SPI_DATA_W      = 8;
    // Each frame bit costs two half-periods: one rising and one falling SCK edge.
    localparam int SPI_SHIFT_TICKS = 2 * SPI_FRAME_BITS;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    // Register-access frame {rd, addr, data}; reads drive zero in the data field.
    function automatic logic [SPI_FRAME_BITS-1:0] spi_frame(
        input logic                  rd,
        input logic [SPI_ADDR_W-1:0] addr,
        input logic [SPI_DATA_W-1:0] data
    );
        return {rd, addr, (rd ? {SPI_DATA_W{1'b0}} : data)};
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - SCK half-period tick generator
//
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   en_i    count enable
//   clr_i   synchronous clear of the counter (wins over en_i)
//   tick_o  one-cycle pulse on the last cycle of every CLK_DIV-cycle half-period
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int              CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_host.sv
// rtl/spi_host.sv - SPI mode-0 initiator issuing 16-bit register-access frames
//
// Ports:
//   i_clk, i_reset_n         system clock, asynchronous active-low reset
//   i_start, i_rd            transaction request (sampled in IDLE), read/write select
//   i_addr, i_wdata          register address and write data, latched at acceptance
//   o_busy, o_done           transaction in progress, one-cycle completion pulse
//   o_rdata                  byte returned by the last read
//   o_spi_cs_n, o_spi_sck    chip select (active low), serial clock (idles low)
//   o_spi_mosi, i_spi_miso   serial data out / in, MSB first
module spi_host
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic                  i_rd,
    input  logic [SPI_ADDR_W-1:0] i_addr,
    input  logic [SPI_DATA_W-1:0] i_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [SPI_DATA_W-1:0] o_rdata,
    output logic                  o_spi_cs_n,
    output logic                  o_spi_sck,
    output logic                  o_spi_mosi,
    input  logic                  i_spi_miso
);

    localparam int            CNT_W     = 8;
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SPI_SHIFT_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);

    spi_state_e                  state_q;
    logic [SPI_FRAME_BITS-2:0]   tx_q;      // frame bits still to send; bit 15 goes straight to MOSI
    logic [SPI_DATA_W-1:0]       rx_q;      // last 8 MISO samples = read data at frame end
    logic [CNT_W-1:0]            cnt_q;     // tick count within SHIFT or GAP
    logic                        rd_q;
    logic                        busy_q, done_q, cs_n_q, sck_q, mosi_q;
    logic [SPI_DATA_W-1:0]       rdata_q;
    logic [SPI_FRAME_BITS-1:0]   frame_w;
    logic                        tick;

    assign frame_w = spi_frame(i_rd, i_addr, i_wdata);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i  (i_clk),
        .rst_ni (i_reset_n),
        .en_i   (state_q != IDLE),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        tx_q    <= frame_w[SPI_FRAME_BITS-2:0];
                        mosi_q  <= frame_w[SPI_RD_BIT];
                        rd_q    <= i_rd;
                        busy_q  <= 1'b1;
                        cs_n_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sck_q <= ~sck_q;
                        if (!sck_q) begin
                            // Rising edge: slave data has been stable since the previous falling edge.
                            rx_q <= {rx_q[SPI_DATA_W-2:0], i_spi_miso};
                        end else begin
                            // Falling edge: present the next bit; the final one shifts out a zero.
                            mosi_q <= tx_q[SPI_FRAME_BITS-2];
                            tx_q   <= {tx_q[SPI_FRAME_BITS-3:0], 1'b0};
                        end
                        if (cnt_q == SHIFT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= HOLD;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_n_q <= 1'b1;
                        mosi_q <= 1'b0;
                        if (rd_q) begin
                            rdata_q <= rx_q;
                        end
                        if (CS_GAP == 0) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (cnt_q == GAP_LAST) begin
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_rdata    = rdata_q;
    assign o_spi_cs_n = cs_n_q;
    assign o_spi_sck  = sck_q;
    assign o_spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_host.sv
// tb/tb_spi_host.sv - directed self-checking bench for spi_host
module tb_spi_host;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Instance A: default timing (CLK_DIV=4, CS_GAP=2)
    logic       start_a = 1'b0, rd_a = 1'b0;
    logic [6:0] addr_a = '0;
    logic [7:0] wdata_a = '0, rdata_a, resp_a = '0;
    logic       busy_a, done_a, cs_n_a, sck_a, mosi_a, miso_a;

    // Instance B: CLK_DIV=2, CS_GAP=0
    logic       start_b = 1'b0, rd_b = 1'b0;
    logic [6:0] addr_b = '0;
    logic [7:0] wdata_b = '0, rdata_b;
    logic       busy_b, done_b, cs_n_b, sck_b, mosi_b;

    spi_host u_dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start_a), .i_rd(rd_a),
        .i_addr(addr_a), .i_wdata(wdata_a), .o_busy(busy_a), .o_done(done_a),
        .o_rdata(rdata_a), .o_spi_cs_n(cs_n_a), .o_spi_sck(sck_a),
        .o_spi_mosi(mosi_a), .i_spi_miso(miso_a)
    );

    spi_host #(.CLK_DIV(2), .CS_GAP(0)) u_dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start_b), .i_rd(rd_b),
        .i_addr(addr_b), .i_wdata(wdata_b), .o_busy(busy_b), .o_done(done_b),
        .o_rdata(rdata_b), .o_spi_cs_n(cs_n_b), .o_spi_sck(sck_b),
        .o_spi_mosi(mosi_b), .i_spi_miso(1'b0)
    );

    // Slave / bus monitor A, sampled on the falling system clock edge
    logic [15:0] cap_a = '0;
    int edges_a = 0, cslow_a = 0, gap_a = 0, gaprun_a = 0, ndone_a = 0;
    logic sck_a_p = 1'b0, cs_n_a_p = 1'b1;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (cs_n_a_p && !cs_n_a) begin
            edges_a  <= 0;
            cap_a    <= '0;
            cslow_a  <= 1;
            gap_a    <= gaprun_a;
            gaprun_a <= 0;
        end else if (!cs_n_a) begin
            cslow_a <= cslow_a + 1;
            if (sck_a && !sck_a_p) begin
                cap_a   <= {cap_a[14:0], mosi_a};
                edges_a <= edges_a + 1;
            end
        end else begin
            gaprun_a <= gaprun_a + 1;
        end
        if (done_a) ndone_a <= ndone_a + 1;
        sck_a_p  <= sck_a;
        cs_n_a_p <= cs_n_a;
    end

    // Responder: return resp_a MSB first during frame bits 7..0
    always_comb begin
        miso_a = 1'b0;
        if (edges_a >= 8 && edges_a < 16) miso_a = resp_a[3'(15 - edges_a)];
    end

    // Monitor B
    logic [15:0] cap_b = '0;
    int edges_b = 0, cslow_b = 0, r0_b = 0, per_b = 0, ndone_b = 0;
    logic sck_b_p = 1'b0, cs_n_b_p = 1'b1;

    always @(negedge clk) begin
        if (cs_n_b_p && !cs_n_b) begin
            edges_b <= 0;
            cap_b   <= '0;
            cslow_b <= 1;
        end else if (!cs_n_b) begin
            cslow_b <= cslow_b + 1;
            if (sck_b && !sck_b_p) begin
                cap_b   <= {cap_b[14:0], mosi_b};
                edges_b <= edges_b + 1;
                if (edges_b == 0) r0_b <= cyc;
                if (edges_b == 1) per_b <= cyc - r0_b;
            end
        end
        if (done_b) ndone_b <= ndone_b + 1;
        sck_b_p  <= sck_b;
        cs_n_b_p <= cs_n_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go_a(input logic rd, input logic [6:0] addr, input logic [7:0] wd);
        @(negedge clk);
        rd_a = rd; addr_a = addr; wdata_a = wd; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // Called one falling edge after the accepting edge; returns cycles from acceptance to o_done
    task automatic wait_done_a(output int lat);
        lat = 0;
        while (!done_a && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat, d0, n;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n_a, 1);
        chk("rst_sck", sck_a, 0);
        chk("rst_mosi", mosi_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_rdata", rdata_a, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Write 7'h05 <- 8'hA5
        go_a(1'b0, 7'h05, 8'hA5);
        chk("wr_busy", busy_a, 1);
        wait_done_a(lat);
        chk("wr_latency", lat, 144);
        chk("wr_mosi", cap_a, 16'h05A5);
        chk("wr_edges", edges_a, 16);
        chk("wr_cs_low", cslow_a, 136);
        chk("wr_busy_end", busy_a, 0);
        @(negedge clk);
        chk("wr_done_pulse", done_a, 0);

        // Read 7'h21, responder returns 8'h3C
        resp_a = 8'h3C;
        go_a(1'b1, 7'h21, 8'hFF);
        wait_done_a(lat);
        chk("rd_latency", lat, 144);
        chk("rd_mosi", cap_a, 16'hA100);
        chk("rd_rdata", rdata_a, 8'h3C);
        go_a(1'b0, 7'h05, 8'h11);
        wait_done_a(lat);
        chk("wr_keeps_rdata", rdata_a, 8'h3C);
        chk("wr2_mosi", cap_a, 16'h0511);

        // Back-to-back with i_start held high
        repeat (4) @(negedge clk);
        d0 = ndone_a;
        rd_a = 1'b0; addr_a = 7'h12; wdata_a = 8'h34; start_a = 1'b1;
        n = 0;
        while (!done_a && n < 400) begin @(negedge clk); n++; end
        @(negedge clk);
        start_a = 1'b0;
        chk("b2b_second_busy", busy_a, 1);
        n = 0;
        while (!done_a && n < 400) begin @(negedge clk); n++; end
        chk("b2b_cs_gap", gap_a, 9);
        chk("b2b_mosi2", cap_a, 16'h1234);
        repeat (20) @(negedge clk);
        chk("b2b_done_count", ndone_a - d0, 2);
        chk("b2b_idle", busy_a, 0);

        // Start while busy is ignored and mid-frame input changes have no effect
        d0 = ndone_a;
        go_a(1'b0, 7'h33, 8'h55);
        repeat (48) @(negedge clk);
        addr_a = 7'h44; wdata_a = 8'h66; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(lat);
        chk("busy_start_mosi", cap_a, 16'h3355);
        repeat (200) @(negedge clk);
        chk("busy_start_dones", ndone_a - d0, 1);
        chk("busy_start_cs", cs_n_a, 1);

        // Asynchronous reset during frame bit 6
        go_a(1'b0, 7'h0F, 8'hF0);
        n = 0;
        while (edges_a < 10 && n < 400) begin @(negedge clk); n++; end
        d0 = ndone_a;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs_n", cs_n_a, 1);
        chk("arst_sck", sck_a, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_mosi", mosi_a, 0);
        chk("arst_rdata", rdata_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("arst_no_done", ndone_a - d0, 0);
        resp_a = 8'hC3;
        go_a(1'b1, 7'h7E, 8'h00);
        wait_done_a(lat);
        chk("arst_rd_latency", lat, 144);
        chk("arst_rd_mosi", cap_a, 16'hFE00);
        chk("arst_rd_rdata", rdata_a, 8'hC3);

        // CLK_DIV=2, CS_GAP=0
        @(negedge clk);
        rd_b = 1'b0; addr_b = 7'h5A; wdata_b = 8'h3C; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        lat = 0;
        while (!done_b && lat < 400) begin @(negedge clk); lat++; end
        chk("b_latency", lat, 68);
        chk("b_mosi", cap_b, 16'h5A3C);
        chk("b_edges", edges_b, 16);
        chk("b_sck_period", per_b, 4);
        chk("b_cs_low", cslow_b, 68);
        chk("b_cs_end", cs_n_b, 1);
        repeat (10) @(negedge clk);
        chk("b_done_count", ndone_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_host.md
Name: spi_host

Overview:
- FPGA-side SPI initiator that drives the same 16-bit register-access frame the board's SPI register slave decodes: 7-bit address, 8-bit data.
- Used by the bring-up/loopback build to exercise the video and PLL control register file without the MCU.
- Also used on a companion FPGA to configure this board over SPI_SCK/SPI_SI/SPI_CSn.
- Mode 0 (CPOL=0, CPHA=0), MSB first.

Parameters:
- CLK_DIV, 4: i_clk cycles per SCK half-period; legal range 2..255.
- CS_GAP, 2: number of SCK half-periods CS_n stays high after a frame before o_done.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  request a transaction; sampled only in IDLE.
- i_rd  in  1  1 = register read, 0 = register write.
- i_addr  in  7  register address.
- i_wdata  in  8  write data; ignored for reads.
- o_busy  out  1  transaction in progress.
- o_done  out  1  one-cycle pulse when the transaction completes.
- o_rdata  out  8  data captured in the last 8 bits of a read; held until the next read.
- o_spi_cs_n  out  1  chip select, active low.
- o_spi_sck  out  1  serial clock, idles low.
- o_spi_mosi  out  1  serial data to the slave.
- i_spi_miso  in  1  serial data from the slave.

Behaviour:
- Frame layout: 16 bits = {i_rd, i_addr[6:0], data[7:0]}.
  - Write: data = i_wdata.
  - Read: data bits are driven 0; the responder returns the register on MISO during bits 7..0.
- Reset (asynchronous, applies mid-frame too): o_spi_cs_n=1, o_spi_sck=0, o_spi_mosi=0, o_busy=0, o_done=0, o_rdata=0, state=IDLE, counters=0. A partial frame is abandoned with no o_done.
- Half-period counter: counts 0..CLK_DIV-1 and pulses tick at CLK_DIV-1. It runs only outside IDLE.
- States:
  - IDLE: when i_start=1, latch the frame into the shift register and move to SETUP on the next edge. That same edge sets o_busy=1, drives o_spi_cs_n=0 and puts frame bit 15 on o_spi_mosi.
  - SETUP: wait one tick (CS-to-first-edge setup time), then SHIFT.
  - SHIFT: 32 ticks, alternating edges.
    - Odd tick = rising SCK edge: sample i_spi_miso into the receive shift register.
    - Even tick = falling SCK edge: shift out the next MOSI bit.
    - After the 32nd tick SCK is low; move to HOLD.
  - HOLD: one tick with SCK low and CS low; then raise CS, copy the receive low byte into o_rdata (reads only) and move to GAP.
  - GAP: CS_GAP ticks with CS high; then o_done=1 for one cycle, o_busy=0, back to IDLE.
- Latency from the accepting i_start edge to o_done: (1 + 32 + 1 + CS_GAP)*CLK_DIV cycles. Defaults give 144.
- Back-to-back: i_start may be high in the same cycle o_done pulses; it is accepted on the following cycle (IDLE). CS therefore stays high for at least CS_GAP half-periods plus 1 cycle.
- i_start while o_busy=1 is ignored; there is no queueing. Inputs are latched at acceptance, so changing i_addr or i_wdata mid-frame has no effect.
- o_spi_mosi returns to 0 when CS rises. o_rdata is unchanged by writes.
- All SPI outputs are registered, with no combinational path from inputs to pins.

Decomposition:
- Package spi_pkg:
  - SPI_FRAME_BITS=16, SPI_RD_BIT=15, SPI_ADDR_W=7, SPI_DATA_W=8.
  - State enum {IDLE, SETUP, SHIFT, HOLD, GAP}.
- Sub-module spi_tick_gen(CLK_DIV): half-period counter with enable, tick output and synchronous clear. Reused by other SPI-timed blocks.
- The FSM and shift registers stay in spi_host.

Test Plan:
- Write: CLK_DIV=4, i_rd=0, i_addr=7'h05, i_wdata=8'hA5. Slave model captures MOSI = 16'h05A5 on rising edges; 16 rising SCK edges; CS low for 136 cycles; o_done 144 cycles after acceptance.
- Read: i_rd=1, i_addr=7'h21. Slave returns 8'h3C. MOSI upper byte = 8'hA1; o_rdata=8'h3C at o_done and still 8'h3C after a following write.
- Back-to-back: i_start held high continuously. Two frames occur; CS high gap = CS_GAP*CLK_DIV+1 = 9 cycles; exactly two o_done pulses.
- Start while busy: pulse i_start at cycle 50 of a frame. No second frame starts and no extra o_done.
- Reset mid-frame: assert i_reset_n=0 during bit 6 of SHIFT. cs_n=1, sck=0, busy=0 within the same cycle with no clock edge needed. A new frame after release is correct.
- CLK_DIV=2, CS_GAP=0: SCK period is 4 cycles; latency is 68 cycles; frame content is correct.
